// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures bypassed operands, decoded fields and control for EX,
// detects load-use hazards (stalling for LU_BUBBLES cycles) and honours branch flush.
module id_ex_pipe #(
    parameter int XLEN       = 32,
    parameter int CTRL_W     = 8,
    parameter int LU_BUBBLES = 1     // 1..3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IF_ID_valid,
    input  logic [XLEN-1:0]   IF_ID_pc,
    input  logic [4:0]        ID_Rs1,
    input  logic [4:0]        ID_Rs2,
    input  logic [4:0]        ID_Rd,
    input  logic [XLEN-1:0]   ID_imm,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic [XLEN-1:0]   RData1,
    input  logic [XLEN-1:0]   RData2,
    input  logic              MEM_WB_RegWrite,
    input  logic [4:0]        RD,
    input  logic [XLEN-1:0]   Write_Data,
    input  logic              flush,
    output logic              stall,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [XLEN-1:0]   ID_EX_A,
    output logic [XLEN-1:0]   ID_EX_B,
    output logic [4:0]        ID_EX_Rs1,
    output logic [4:0]        ID_EX_Rs2,
    output logic [4:0]        ID_EX_Rd,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              hazard;
    logic              load_instr;
    logic [XLEN-1:0]   op_a, op_b;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;

    // The register file write lands on the next edge, so same-cycle writeback is forwarded here.
    always_comb begin
        if (ID_Rs1 == 5'd0)
            op_a = '0;
        else if (MEM_WB_RegWrite && (RD != 5'd0) && (RD == ID_Rs1))
            op_a = Write_Data;
        else
            op_a = RData1;
    end

    always_comb begin
        if (ID_Rs2 == 5'd0)
            op_b = '0;
        else if (MEM_WB_RegWrite && (RD != 5'd0) && (RD == ID_Rs2))
            op_b = Write_Data;
        else
            op_b = RData2;
    end

    assign hazard = IF_ID_valid & valid_q & memread_q & (rd_q != 5'd0) &
                    ((rd_q == ID_Rs1) | (rd_q == ID_Rs2));

    assign stall = ~flush & (((state_q == ST_RUN) & hazard) | (state_q == ST_STALL));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_instr = 1'b0;
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
        end else if (state_q == ST_STALL) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1)
                state_d = ST_RUN;
        end else if (hazard) begin
            // A single bubble needs no extra state; longer penalties count down in STALL.
            if (LU_BUBBLES > 1) begin
                state_d = ST_STALL;
                cnt_d   = 2'(LU_BUBBLES - 1);
            end
        end else begin
            load_instr = IF_ID_valid;
        end
    end

    // Anything other than a clean advance loads an all-zero bubble.
    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        imm_d      = '0;
        a_d        = '0;
        b_d        = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        ctrl_d     = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        if (load_instr) begin
            valid_d    = 1'b1;
            pc_d       = IF_ID_pc;
            imm_d      = ID_imm;
            a_d        = op_a;
            b_d        = op_b;
            rs1_d      = ID_Rs1;
            rs2_d      = ID_Rs2;
            rd_d       = ID_Rd;
            ctrl_d     = ID_ctrl;
            regwrite_d = ID_RegWrite;
            memread_d  = ID_MemRead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= 2'd0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    assign ID_EX_valid    = valid_q;
    assign ID_EX_pc       = pc_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_A        = a_q;
    assign ID_EX_B        = b_q;
    assign ID_EX_Rs1      = rs1_q;
    assign ID_EX_Rs2      = rs2_q;
    assign ID_EX_Rd       = rd_q;
    assign ID_EX_ctrl     = ctrl_q;
    assign ID_EX_RegWrite = regwrite_q;
    assign ID_EX_MemRead  = memread_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: lane 0 runs LU_BUBBLES=1, lane 1 runs LU_BUBBLES=3, each against
// a cycle-level reference model of the decode->EX hand-off, with directed and random traffic.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid [2];
    logic [31:0] if_pc    [2];
    logic [4:0]  id_rs1   [2];
    logic [4:0]  id_rs2   [2];
    logic [4:0]  id_rd    [2];
    logic [31:0] id_imm   [2];
    logic [7:0]  id_ctrl  [2];
    logic        id_rw    [2];
    logic        id_mr    [2];
    logic [31:0] rdata1   [2];
    logic [31:0] rdata2   [2];
    logic        wb_en    [2];
    logic [4:0]  wb_rd    [2];
    logic [31:0] wb_data  [2];
    logic        flush    [2];
    logic        stall    [2];
    logic        ex_valid [2];
    logic [31:0] ex_pc    [2];
    logic [31:0] ex_imm   [2];
    logic [31:0] ex_a     [2];
    logic [31:0] ex_b     [2];
    logic [4:0]  ex_rs1   [2];
    logic [4:0]  ex_rs2   [2];
    logic [4:0]  ex_rd    [2];
    logic [7:0]  ex_ctrl  [2];
    logic        ex_rw    [2];
    logic        ex_mr    [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        id_ex_pipe #(.XLEN(32), .CTRL_W(8), .LU_BUBBLES(gi == 0 ? 1 : 3)) dut (
            .clk(clk), .rst_n(rst_n),
            .IF_ID_valid(if_valid[gi]), .IF_ID_pc(if_pc[gi]),
            .ID_Rs1(id_rs1[gi]), .ID_Rs2(id_rs2[gi]), .ID_Rd(id_rd[gi]),
            .ID_imm(id_imm[gi]), .ID_ctrl(id_ctrl[gi]),
            .ID_RegWrite(id_rw[gi]), .ID_MemRead(id_mr[gi]),
            .RData1(rdata1[gi]), .RData2(rdata2[gi]),
            .MEM_WB_RegWrite(wb_en[gi]), .RD(wb_rd[gi]), .Write_Data(wb_data[gi]),
            .flush(flush[gi]), .stall(stall[gi]),
            .ID_EX_valid(ex_valid[gi]), .ID_EX_pc(ex_pc[gi]), .ID_EX_imm(ex_imm[gi]),
            .ID_EX_A(ex_a[gi]), .ID_EX_B(ex_b[gi]),
            .ID_EX_Rs1(ex_rs1[gi]), .ID_EX_Rs2(ex_rs2[gi]), .ID_EX_Rd(ex_rd[gi]),
            .ID_EX_ctrl(ex_ctrl[gi]), .ID_EX_RegWrite(ex_rw[gi]), .ID_EX_MemRead(ex_mr[gi])
        );
    end

    int n_checks = 0;
    int n_fails  = 0;
    int stall_seen;

    // Reference model: instruction stream plus what EX should hold and remaining penalty cycles.
    instr_t      prog [$];
    instr_t      m_ex;
    logic [31:0] m_a, m_b;
    int          wait_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic rw, input logic mr);
        instr_t i;
        i.valid = v;
        i.pc    = $urandom;
        i.rs1   = rs1;
        i.rs2   = rs2;
        i.rd    = rd;
        i.imm   = $urandom;
        i.ctrl  = 8'($urandom);
        i.rw    = rw;
        i.mr    = mr;
        return i;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic we,
                                            input logic [4:0] wr, input logic [31:0] wd,
                                            input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (we && wr != 5'd0 && wr == rs) return wd;
        return rf;
    endfunction

    task automatic reset_model();
        prog.delete();
        m_ex      = '0;
        m_a       = '0;
        m_b       = '0;
        wait_left = 0;
    endtask

    task automatic check_ex(input int ln);
        check($sformatf("L%0d valid", ln), 32'(ex_valid[ln]), 32'(m_ex.valid));
        check($sformatf("L%0d pc", ln), ex_pc[ln], m_ex.pc);
        check($sformatf("L%0d imm", ln), ex_imm[ln], m_ex.imm);
        check($sformatf("L%0d A", ln), ex_a[ln], m_a);
        check($sformatf("L%0d B", ln), ex_b[ln], m_b);
        check($sformatf("L%0d regs", ln), {17'd0, ex_rs1[ln], ex_rs2[ln], ex_rd[ln]},
              {17'd0, m_ex.rs1, m_ex.rs2, m_ex.rd});
        check($sformatf("L%0d ctrl", ln), {22'd0, ex_ctrl[ln], ex_rw[ln], ex_mr[ln]},
              {22'd0, m_ex.ctrl, m_ex.rw, m_ex.mr});
    endtask

    // One clock of traffic on a lane: drive at negedge, check stall, clock, check EX contents.
    task automatic run_cycle(input int ln, input logic fl, input logic we, input logic [4:0] wr,
                             input logic [31:0] wd, input logic [31:0] r1, input logic [31:0] r2);
        instr_t s;
        logic   dep, st_exp;
        int     lu;
        lu = (ln == 0) ? 1 : 3;
        s  = (prog.size() > 0) ? prog[0] : instr_t'(0);
        @(negedge clk);
        if_valid[ln] = s.valid;  if_pc[ln]   = s.pc;
        id_rs1[ln]   = s.rs1;    id_rs2[ln]  = s.rs2;   id_rd[ln] = s.rd;
        id_imm[ln]   = s.imm;    id_ctrl[ln] = s.ctrl;
        id_rw[ln]    = s.rw;     id_mr[ln]   = s.mr;
        rdata1[ln]   = r1;       rdata2[ln]  = r2;
        wb_en[ln]    = we;       wb_rd[ln]   = wr;      wb_data[ln] = wd;
        flush[ln]    = fl;
        #1;
        dep = s.valid && m_ex.valid && m_ex.mr && m_ex.rd != 5'd0 &&
              (m_ex.rd == s.rs1 || m_ex.rd == s.rs2);
        st_exp = fl ? 1'b0 : ((wait_left > 0) ? 1'b1 : dep);
        check($sformatf("L%0d stall", ln), 32'(stall[ln]), 32'(st_exp));
        if (stall[ln] === 1'b1) stall_seen++;
        @(posedge clk);
        #1;
        if (fl) begin
            m_ex = '0; m_a = '0; m_b = '0; wait_left = 0;
        end else if (wait_left > 0) begin
            m_ex = '0; m_a = '0; m_b = '0; wait_left--;
        end else if (dep) begin
            m_ex = '0; m_a = '0; m_b = '0; wait_left = lu - 1;
        end else if (s.valid) begin
            m_ex = s;
            m_a  = operand(s.rs1, we, wr, wd, r1);
            m_b  = operand(s.rs2, we, wr, wd, r2);
        end else begin
            m_ex = '0; m_a = '0; m_b = '0;
        end
        if (!st_exp && prog.size() > 0) void'(prog.pop_front());
        check_ex(ln);
    endtask

    task automatic quiet_cycle(input int ln);
        run_cycle(ln, 1'b0, 1'b0, 5'd0, 32'd0, $urandom, $urandom);
    endtask

    task automatic random_traffic(input int ln, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (prog.size() < 2)
                prog.push_back(mk(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                  1'($urandom), 1'($urandom_range(0, 2) == 0)));
            run_cycle(ln, 1'($urandom_range(0, 11) == 0), 1'($urandom),
                      5'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        end
        $display("L%0d random: %0d cycles", ln, cycles);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if_valid[l] = 0; if_pc[l] = 0; id_rs1[l] = 0; id_rs2[l] = 0; id_rd[l] = 0;
            id_imm[l] = 0; id_ctrl[l] = 0; id_rw[l] = 0; id_mr[l] = 0; rdata1[l] = 0;
            rdata2[l] = 0; wb_en[l] = 0; wb_rd[l] = 0; wb_data[l] = 0; flush[l] = 0;
        end
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_ex(0);
        check("L0 stall after reset", 32'(stall[0]), 32'd0);

        // Same-cycle writeback forwarding, then a writeback to x0 that must not forward
        prog.push_back(mk(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0));
        run_cycle(0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'd5, 32'd7);
        check("T2 A bypass", ex_a[0], 32'hDEAD_BEEF);
        prog.push_back(mk(1'b1, 5'd5, 5'd6, 5'd9, 1'b1, 1'b0));
        run_cycle(0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'd5, 32'd7);
        check("T2 A no x0 bypass", ex_a[0], 32'd5);
        $display("T2 bypass: A=%h", ex_a[0]);

        // lw x7 ; add x8,x7,x1 with a single-bubble penalty
        prog.push_back(mk(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0));
        stall_seen = 0;
        repeat (3) quiet_cycle(0);
        check("T3 stall cycles", stall_seen, 32'd1);
        check("T3 add captured", {27'd0, ex_rd[0]}, 32'd8);
        $display("T3 load-use LU=1: stall cycles=%0d", stall_seen);

        // Load into x0 never creates a hazard; x0 operand reads as zero
        prog.push_back(mk(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0));
        stall_seen = 0;
        run_cycle(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1234, 32'h5678);
        run_cycle(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'h1234, 32'h5678);
        check("T6 stall cycles", stall_seen, 32'd0);
        check("T6 A of x0", ex_a[0], 32'd0);
        $display("T6 load x0: stall cycles=%0d A=%h", stall_seen, ex_a[0]);

        random_traffic(0, 300);
        prog.delete();
        quiet_cycle(0);
        if_valid[0] = 1'b0;
        flush[0]    = 1'b0;

        // Lane 1 has only ever seen idle inputs, so EX holds a bubble
        reset_model();
        prog.push_back(mk(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0));
        stall_seen = 0;
        repeat (5) quiet_cycle(1);
        check("T4 stall cycles", stall_seen, 32'd3);
        check("T4 add captured", {27'd0, ex_rd[1]}, 32'd8);
        $display("T4 load-use LU=3: stall cycles=%0d", stall_seen);

        // Flush in the second stall cycle kills the add; the following instruction enters
        prog.push_back(mk(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0));
        prog.push_back(mk(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0));
        stall_seen = 0;
        quiet_cycle(1);
        quiet_cycle(1);
        run_cycle(1, 1'b1, 1'b0, 5'd0, 32'd0, $urandom, $urandom);
        check("T5 bubble after flush", 32'(ex_valid[1]), 32'd0);
        quiet_cycle(1);
        check("T5 stall cycles", stall_seen, 32'd1);
        check("T5 next captured", {27'd0, ex_rd[1]}, 32'd10);
        $display("T5 flush in stall: stall cycles=%0d rd=%0d", stall_seen, ex_rd[1]);

        random_traffic(1, 300);
        prog.delete();
        quiet_cycle(1);
        flush[1] = 1'b0;

        // Asynchronous reset in the middle of a STALL sequence
        reset_model();
        prog.push_back(mk(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1));
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0));
        quiet_cycle(1);
        quiet_cycle(1);
        #2;
        rst_n = 1'b0;
        #1;
        prog.delete();
        reset_model();
        check("T1 stall in reset", 32'(stall[1]), 32'd0);
        check("T1 stall L0 in reset", 32'(stall[0]), 32'd0);
        check_ex(1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prog.push_back(mk(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0));
        quiet_cycle(1);
        check("T1 captured after reset", 32'(ex_valid[1]), 32'd1);
        $display("T1 reset mid-stall: valid=%0d rd=%0d", ex_valid[1], ex_rd[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
